// File: rtl/rv_alu_share_arb.sv
// rv_alu_share_arb: round-robin sequencer sharing one combinational ALU between two requesters
module rv_alu_share_arb #(
  parameter int BUS_W = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic [OP_W-1:0]  req0Op,
  input  logic [BUS_W-1:0] req0A,
  input  logic [BUS_W-1:0] req0B,
  output logic             rsp0Valid,
  input  logic             rsp0Ready,
  output logic [BUS_W-1:0] rsp0Data,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic [OP_W-1:0]  req1Op,
  input  logic [BUS_W-1:0] req1A,
  input  logic [BUS_W-1:0] req1B,
  output logic             rsp1Valid,
  input  logic             rsp1Ready,
  output logic [BUS_W-1:0] rsp1Data,
  output logic [OP_W-1:0]  aluOp,
  output logic [BUS_W-1:0] srcA,
  output logic [BUS_W-1:0] srcB,
  input  logic [BUS_W-1:0] aluOut,
  output logic             busy
);
  logic busy_q, busy_d, owner_q, owner_d, last_q, last_d;
  logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [BUS_W-1:0] a_q, a_d, b_q, b_d;
  logic [BUS_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic elig0, elig1, acc0, acc1, done0, done1;
  always_comb begin
    elig0 = !(busy_q && !owner_q) && !rsp0_valid_q;
    elig1 = !(busy_q && owner_q) && !rsp1_valid_q;
    req0Ready = elig0 && !(req1Valid && elig1 && !last_q);
    req1Ready = elig1 && !(req0Valid && elig0 && last_q);
    acc0 = req0Valid && req0Ready;
    acc1 = req1Valid && req1Ready;
    done0 = busy_q && !owner_q;
    done1 = busy_q && owner_q;
    busy_d = acc0 || acc1;
    owner_d = acc1 ? 1'b1 : acc0 ? 1'b0 : owner_q;
    last_d = acc1 ? 1'b1 : acc0 ? 1'b0 : last_q;
    op_d = acc1 ? req1Op : acc0 ? req0Op : op_q;
    a_d = acc1 ? req1A : acc0 ? req0A : a_q;
    b_d = acc1 ? req1B : acc0 ? req0B : b_q;
    rsp0_valid_d = done0 ? 1'b1 : (rsp0_valid_q && rsp0Ready) ? 1'b0 : rsp0_valid_q;
    rsp1_valid_d = done1 ? 1'b1 : (rsp1_valid_q && rsp1Ready) ? 1'b0 : rsp1_valid_q;
    rsp0_data_d = done0 ? aluOut : rsp0_data_q;
    rsp1_data_d = done1 ? aluOut : rsp1_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      busy_q <= busy_d;
      owner_q <= owner_d;
      last_q <= last_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end
  assign busy = busy_q;
  assign aluOp = op_q;
  assign srcA = a_q;
  assign srcB = b_q;
  assign rsp0Valid = rsp0_valid_q;
  assign rsp1Valid = rsp1_valid_q;
  assign rsp0Data = rsp0_data_q;
  assign rsp1Data = rsp1_data_q;
endmodule

// File: tb/tb_rv_alu_share_arb.sv
// tb_rv_alu_share_arb: directed checks of the shared-ALU arbiter with a behavioural RV ALU
module tb_rv_alu_share_arb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0Valid = 0, req1Valid = 0, rsp0Ready = 0, rsp1Ready = 0;
  logic req0Ready, req1Ready, rsp0Valid, rsp1Valid, busy;
  logic [3:0] req0Op = 0, req1Op = 0, aluOp;
  logic [31:0] req0A = 0, req0B = 0, req1A = 0, req1B = 0;
  logic [31:0] rsp0Data, rsp1Data, srcA, srcB, aluOut;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  rv_alu_share_arb #(.BUS_W(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Op(req0Op), .req0A(req0A), .req0B(req0B),
    .rsp0Valid(rsp0Valid), .rsp0Ready(rsp0Ready), .rsp0Data(rsp0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Op(req1Op), .req1A(req1A), .req1B(req1B),
    .rsp1Valid(rsp1Valid), .rsp1Ready(rsp1Ready), .rsp1Data(rsp1Data),
    .aluOp(aluOp), .srcA(srcA), .srcB(srcB), .aluOut(aluOut), .busy(busy)
  );
  always_comb begin
    case (aluOp)
      4'b0000: aluOut = srcA + srcB;
      4'b1000: aluOut = srcA - srcB;
      4'b0001: aluOut = srcA << srcB[4:0];
      4'b0010: aluOut = {31'd0, $signed(srcA) < $signed(srcB)};
      4'b0011: aluOut = {31'd0, srcA < srcB};
      4'b0100: aluOut = srcA ^ srcB;
      4'b0101: aluOut = srcA >> srcB[4:0];
      4'b1101: aluOut = $signed(srcA) >>> srcB[4:0];
      4'b0110: aluOut = srcA | srcB;
      4'b0111: aluOut = srcA & srcB;
      4'b1111: aluOut = srcA + 32'd4;
      default: aluOut = 32'd0;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    req0Valid = 0; req1Valid = 0; rsp0Ready = 0; rsp1Ready = 0;
    step();
    rst_n = 1;
  endtask
  initial begin
    // 1: reset values
    step();
    chk("rst_busy", busy, 0);
    chk("rst_rsp0v", rsp0Valid, 0);
    chk("rst_rsp1v", rsp1Valid, 0);
    chk("rst_rsp0d", rsp0Data, 0);
    chk("rst_rsp1d", rsp1Data, 0);
    chk("rst_op", aluOp, 0);
    chk("rst_srca", srcA, 0);
    chk("rst_srcb", srcB, 0);
    rst_n = 1;
    step();
    chk("rst_rdy0", req0Ready, 1);
    chk("rst_rdy1", req1Ready, 1);
    // 2: single ADD
    req0Valid = 1; req0Op = 4'b0000; req0A = 5; req0B = 7;
    #1 chk("add_rdy0", req0Ready, 1);
    step();
    req0Valid = 0;
    chk("add_op", aluOp, 4'b0000);
    chk("add_srca", srcA, 5);
    chk("add_srcb", srcB, 7);
    chk("add_busy", busy, 1);
    chk("add_rdy0_n1", req0Ready, 0);
    chk("add_rsp0v_n1", rsp0Valid, 0);
    step();
    chk("add_rsp0v", rsp0Valid, 1);
    chk("add_rsp0d", rsp0Data, 12);
    chk("add_rdy0_n2", req0Ready, 0);
    chk("add_busy_n2", busy, 0);
    rsp0Ready = 1;
    step();
    rsp0Ready = 0;
    chk("add_rsp0v_done", rsp0Valid, 0);
    chk("add_rsp0d_hold", rsp0Data, 12);
    chk("add_rdy0_back", req0Ready, 1);
    // 3: tie after reset, round robin
    do_reset();
    req0Valid = 1; req0Op = 4'b1000; req0A = 10; req0B = 3;
    req1Valid = 1; req1Op = 4'b0010; req1A = 32'hFFFF_FFFF; req1B = 1;
    #1;
    chk("tie_rdy0", req0Ready, 1);
    chk("tie_rdy1", req1Ready, 0);
    step();
    req0Valid = 0;
    chk("tie_rdy1_n1", req1Ready, 1);
    chk("tie_op_n1", aluOp, 4'b1000);
    chk("tie_srca_n1", srcA, 10);
    step();
    req1Valid = 0;
    chk("tie_rsp0v", rsp0Valid, 1);
    chk("tie_rsp0d", rsp0Data, 7);
    chk("tie_op_n2", aluOp, 4'b0010);
    chk("tie_busy_n2", busy, 1);
    rsp0Ready = 1;
    step();
    chk("tie_rsp1v", rsp1Valid, 1);
    chk("tie_rsp1d", rsp1Data, 1);
    chk("tie_rsp0v_done", rsp0Valid, 0);
    rsp0Ready = 0; rsp1Ready = 1;
    step();
    rsp1Ready = 0;
    chk("tie_rsp1v_done", rsp1Valid, 0);
    req0Valid = 1; req1Valid = 1;
    #1;
    chk("tie2_rdy0", req0Ready, 1);
    chk("tie2_rdy1", req1Ready, 0);
    req0Valid = 0; req1Valid = 0;
    // 4: backpressured rsp0 while req1 proceeds
    #1;
    req0Valid = 1; req0Op = 4'b0000; req0A = 32'hF0; req0B = 0;
    step();
    req0Valid = 0;
    req1Valid = 1; req1Op = 4'b0001; req1A = 1; req1B = 4;
    #1 chk("bp_rdy1", req1Ready, 1);
    step();
    req1Valid = 0; rsp1Ready = 1;
    chk("bp_rsp0v_c2", rsp0Valid, 1);
    chk("bp_rsp0d_c2", rsp0Data, 32'hF0);
    step();
    chk("bp_rsp1v", rsp1Valid, 1);
    chk("bp_rsp1d", rsp1Data, 32'h10);
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp0v_hold", rsp0Valid, 1);
      chk("bp_rsp0d_hold", rsp0Data, 32'hF0);
      chk("bp_rdy0_hold", req0Ready, 0);
      step();
    end
    rsp1Ready = 0;
    chk("bp_rsp1v_done", rsp1Valid, 0);
    rsp0Ready = 1;
    step();
    rsp0Ready = 0;
    chk("bp_rsp0v_done", rsp0Valid, 0);
    chk("bp_rsp0d_keep", rsp0Data, 32'hF0);
    // 5: alternating stream; each requester is blocked while its result drains
    do_reset();
    rsp0Ready = 1; rsp1Ready = 1;
    req0Valid = 1; req0Op = 4'b1111; req0A = 32'h100; req0B = 0;
    req1Valid = 1; req1Op = 4'b1101; req1A = 32'h8000_0000; req1B = 4;
    #1 chk("alt_rdy0_c0", req0Ready, 1);
    step();
    chk("alt_busy_c1", busy, 1);
    chk("alt_op_c1", aluOp, 4'b1111);
    chk("alt_rdy1_c1", req1Ready, 1);
    step();
    chk("alt_busy_c2", busy, 1);
    chk("alt_rsp0d_c2", rsp0Data, 32'h104);
    chk("alt_rsp0v_c2", rsp0Valid, 1);
    chk("alt_op_c2", aluOp, 4'b1101);
    step();
    chk("alt_busy_c3", busy, 0);
    chk("alt_rsp1v_c3", rsp1Valid, 1);
    chk("alt_rsp1d_c3", rsp1Data, 32'hF800_0000);
    chk("alt_rdy0_c3", req0Ready, 1);
    step();
    req0Valid = 0; req1Valid = 0;
    chk("alt_busy_c4", busy, 1);
    chk("alt_srca_c4", srcA, 32'h100);
    step();
    chk("alt_rsp0v_c5", rsp0Valid, 1);
    chk("alt_rsp0d_c5", rsp0Data, 32'h104);
    step();
    chk("alt_rsp0v_c6", rsp0Valid, 0);
    rsp0Ready = 0; rsp1Ready = 0;
    // 6: reset during execute
    req0Valid = 1; req0Op = 4'b0000; req0A = 3; req0B = 3;
    step();
    req0Valid = 0;
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_busy_rst", busy, 0);
    chk("mid_op_rst", aluOp, 0);
    chk("mid_srca_rst", srcA, 0);
    chk("mid_rsp0d_rst", rsp0Data, 0);
    step();
    rst_n = 1;
    step();
    chk("mid_rsp0v_none", rsp0Valid, 0);
    step();
    chk("mid_rsp0v_none2", rsp0Valid, 0);
    req0Valid = 1; req0Op = 4'b0000; req0A = 1; req0B = 1;
    step();
    req0Valid = 0;
    chk("post_rsp0v_n1", rsp0Valid, 0);
    step();
    chk("post_rsp0v_n2", rsp0Valid, 1);
    chk("post_rsp0d_n2", rsp0Data, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
